// File: rtl/caminho_dados_v2.sv
// Register-file datapath with PC/SP/IR/MAR/MDR/CCR, two source buses and a
// three-state memory handshake (idle, request, done) with latched address/write data.
module caminho_dados_v2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4,
  localparam int unsigned RW = $clog2(NREGS),
  localparam int unsigned SW = RW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SW-1:0]    bus1_sel,
  input  logic [1:0]       bus2_sel,
  input  logic             reg_load,
  input  logic [RW-1:0]    reg_dst,
  input  logic             pc_load,
  input  logic             pc_inc,
  input  logic             ir_load,
  input  logic             mar_load,
  input  logic             ccr_load,
  input  logic             sp_push,
  input  logic             sp_pop,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       nzvc,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] bus1_out,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] SP,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic [3:0]       CCR,
  output logic             busy,
  output logic             done,
  output logic             stack_err
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} mem_state_e;

  mem_state_e       state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [WIDTH-1:0] sp_q, sp_d;
  logic [3:0]       ccr_q, ccr_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] bus1, bus2;

  // Bus1: MSB clear selects a general register, set selects a special register.
  always_comb begin
    bus1 = '0;
    if (!bus1_sel[SW-1]) begin
      bus1 = regs_q[bus1_sel[RW-1:0]];
    end else if (bus1_sel[RW-1:0] == RW'(0)) begin
      bus1 = pc_q;
    end else if (bus1_sel[RW-1:0] == RW'(1)) begin
      bus1 = sp_q;
    end else if (bus1_sel[RW-1:0] == RW'(2)) begin
      bus1 = mdr_q;
    end
  end

  always_comb begin
    bus2 = bus1;
    case (bus2_sel)
      2'b00:   bus2 = bus1;
      2'b01:   bus2 = WIDTH'(1);
      2'b10:   bus2 = mdr_q;
      default: bus2 = alu_result;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (reg_load) begin
      regs_d[reg_dst] = bus2;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    ccr_d = ccr_q;
    if (pc_load) begin
      pc_d = bus2;
    end else if (pc_inc) begin
      pc_d = pc_q + WIDTH'(1);
    end
    if (ir_load) begin
      ir_d = bus2;
    end
    if (mar_load) begin
      mar_d = bus2;
    end
    if (ccr_load) begin
      ccr_d = nzvc;
    end
  end

  // Over/underflowing stack operations are refused and latch a sticky fault.
  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    if (sp_push && !sp_pop) begin
      if (sp_q == '0) begin
        err_d = 1'b1;
      end else begin
        sp_d = sp_q - WIDTH'(1);
      end
    end else if (sp_pop && !sp_push) begin
      if (sp_q == '1) begin
        err_d = 1'b1;
      end else begin
        sp_d = sp_q + WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    mdr_d   = mdr_q;
    unique case (state_q)
      StIdle: begin
        if (mem_rd || mem_wr) begin
          state_d = StReq;
          addr_d  = mar_q;
          wdata_d = bus1;
          we_d    = !mem_rd;
        end
      end
      StReq: begin
        if (mem_ack) begin
          state_d = StDone;
          if (!we_q) begin
            mdr_d = mem_rdata;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      sp_q    <= '1;
      ccr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      sp_q    <= sp_d;
      ccr_q   <= ccr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decode straight from state so reset drops them at once.
  assign mem_req   = (state_q == StReq);
  assign mem_we    = (state_q == StReq) && we_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign address   = addr_q;
  assign mem_wdata = wdata_q;
  assign bus1_out  = bus1;
  assign IR        = ir_q;
  assign PC        = pc_q;
  assign SP        = sp_q;
  assign MAR       = mar_q;
  assign MDR       = mdr_q;
  assign CCR       = ccr_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_caminho_dados_v2.sv
// Self-checking bench: table of register-path vectors plus hand-written memory,
// stack and reset sequences; a second 16-bit/8-register instance covers wide use.
module tb_caminho_dados_v2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // 8-bit, 4-register instance
  logic [2:0] bus1_sel;
  logic [1:0] bus2_sel, reg_dst;
  logic reg_load, pc_load, pc_inc, ir_load, mar_load, ccr_load, sp_push, sp_pop;
  logic mem_rd, mem_wr, mem_ack;
  logic [7:0] mem_rdata, alu_result;
  logic [3:0] nzvc;
  logic mem_req, mem_we, busy, done, stack_err;
  logic [7:0] address, mem_wdata, bus1_out, ir_o, pc_o, sp_o, mar_o, mdr_o;
  logic [3:0] ccr_o;

  caminho_dados_v2 #(.WIDTH(8), .NREGS(4)) u_dut (
    .clock(clock), .reset(reset), .bus1_sel(bus1_sel), .bus2_sel(bus2_sel),
    .reg_load(reg_load), .reg_dst(reg_dst), .pc_load(pc_load), .pc_inc(pc_inc),
    .ir_load(ir_load), .mar_load(mar_load), .ccr_load(ccr_load), .sp_push(sp_push),
    .sp_pop(sp_pop), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .alu_result(alu_result), .nzvc(nzvc), .mem_req(mem_req),
    .mem_we(mem_we), .address(address), .mem_wdata(mem_wdata), .bus1_out(bus1_out),
    .IR(ir_o), .PC(pc_o), .SP(sp_o), .MAR(mar_o), .MDR(mdr_o), .CCR(ccr_o),
    .busy(busy), .done(done), .stack_err(stack_err)
  );

  // 16-bit, 8-register instance
  logic [3:0] w_bus1_sel;
  logic [1:0] w_bus2_sel;
  logic [2:0] w_reg_dst;
  logic w_reg_load, w_pc_load, w_pc_inc, w_ir_load, w_mar_load, w_ccr_load;
  logic w_sp_push, w_sp_pop, w_mem_rd, w_mem_wr, w_mem_ack;
  logic [15:0] w_mem_rdata, w_alu_result;
  logic [3:0] w_nzvc;
  logic w_mem_req, w_mem_we, w_busy, w_done, w_stack_err;
  logic [15:0] w_address, w_mem_wdata, w_bus1_out, w_ir, w_pc, w_sp, w_mar, w_mdr;
  logic [3:0] w_ccr;

  caminho_dados_v2 #(.WIDTH(16), .NREGS(8)) u_dut16 (
    .clock(clock), .reset(reset), .bus1_sel(w_bus1_sel), .bus2_sel(w_bus2_sel),
    .reg_load(w_reg_load), .reg_dst(w_reg_dst), .pc_load(w_pc_load), .pc_inc(w_pc_inc),
    .ir_load(w_ir_load), .mar_load(w_mar_load), .ccr_load(w_ccr_load),
    .sp_push(w_sp_push), .sp_pop(w_sp_pop), .mem_rd(w_mem_rd), .mem_wr(w_mem_wr),
    .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata), .alu_result(w_alu_result),
    .nzvc(w_nzvc), .mem_req(w_mem_req), .mem_we(w_mem_we), .address(w_address),
    .mem_wdata(w_mem_wdata), .bus1_out(w_bus1_out), .IR(w_ir), .PC(w_pc), .SP(w_sp),
    .MAR(w_mar), .MDR(w_mdr), .CCR(w_ccr), .busy(w_busy), .done(w_done),
    .stack_err(w_stack_err)
  );

  typedef struct packed {
    logic [2:0] b1sel;
    logic [1:0] b2sel;
    logic       rl;
    logic [1:0] rdst;
    logic       pcl, pci, irl, marl, ccrl, push, pop;
    logic [7:0] alu;
    logic [3:0] nz;
    logic [7:0] e_bus1, e_pc, e_ir, e_mar;
    logic [3:0] e_ccr;
    logic [7:0] e_sp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus1_sel = '0; bus2_sel = '0; reg_load = 0; reg_dst = '0; pc_load = 0; pc_inc = 0;
    ir_load = 0; mar_load = 0; ccr_load = 0; sp_push = 0; sp_pop = 0;
    mem_rd = 0; mem_wr = 0; mem_ack = 0; mem_rdata = '0; alu_result = '0; nzvc = '0;
    w_bus1_sel = '0; w_bus2_sel = '0; w_reg_load = 0; w_reg_dst = '0; w_pc_load = 0;
    w_pc_inc = 0; w_ir_load = 0; w_mar_load = 0; w_ccr_load = 0; w_sp_push = 0;
    w_sp_pop = 0; w_mem_rd = 0; w_mem_wr = 0; w_mem_ack = 0; w_mem_rdata = '0;
    w_alu_result = '0; w_nzvc = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //         b1     b2    rl rd  pcl pci irl mar ccr psh pop alu    nz    bus1   pc     ir     mar   ccr   sp
    vecs[0]  = '{3'b000, 2'b01, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 8'hFF};
    vecs[1]  = '{3'b010, 2'b00, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h01, 8'h01, 8'h00, 8'h00, 4'h0, 8'hFF};
    vecs[2]  = '{3'b100, 2'b00, 0, 2'd0, 0, 0, 1, 1, 0, 0, 0, 8'h00, 4'h0, 8'h01, 8'h01, 8'h01, 8'h01, 4'h0, 8'hFF};
    vecs[3]  = '{3'b000, 2'b11, 0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 8'h40, 4'h0, 8'h00, 8'h40, 8'h01, 8'h01, 4'h0, 8'hFF};
    vecs[4]  = '{3'b100, 2'b00, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h40, 8'h41, 8'h01, 8'h01, 4'h0, 8'hFF};
    vecs[5]  = '{3'b101, 2'b00, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 4'hA, 8'hFF, 8'h41, 8'h01, 8'h01, 4'hA, 8'hFF};
    vecs[6]  = '{3'b101, 2'b00, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 4'h0, 8'hFF, 8'h41, 8'h01, 8'h01, 4'hA, 8'hFE};
    vecs[7]  = '{3'b101, 2'b00, 0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 4'h0, 8'hFE, 8'h41, 8'h01, 8'h01, 4'hA, 8'hFE};
    vecs[8]  = '{3'b101, 2'b00, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 4'h0, 8'hFE, 8'h41, 8'h01, 8'h01, 4'hA, 8'hFF};
    vecs[9]  = '{3'b111, 2'b11, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 8'hFF, 4'h0, 8'h00, 8'hFF, 8'h01, 8'h01, 4'hA, 8'hFF};
    vecs[10] = '{3'b100, 2'b00, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'hFF, 8'h00, 8'h01, 8'h01, 4'hA, 8'hFF};
    vecs[11] = '{3'b110, 2'b10, 0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 4'h0, 8'h00, 8'h00, 8'h01, 8'h00, 4'hA, 8'hFF};
    vecs[12] = '{3'b011, 2'b01, 1, 2'd3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00, 8'h00, 8'h01, 8'h00, 4'hA, 8'hFF};
    vecs[13] = '{3'b011, 2'b11, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 8'h77, 4'h5, 8'h01, 8'h00, 8'h77, 8'h00, 4'hA, 8'hFF};
    vecs[14] = '{3'b010, 2'b00, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h01, 8'h00, 8'h77, 8'h00, 4'hA, 8'hFF};
    vecs[15] = '{3'b000, 2'b00, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h01, 8'h00, 8'h77, 8'h00, 4'hA, 8'hFF};

    idle_inputs();
    #12 reset = 1'b1;
    step();

    chk("rst_pc", pc_o, 0);       chk("rst_ir", ir_o, 0);      chk("rst_mar", mar_o, 0);
    chk("rst_mdr", mdr_o, 0);     chk("rst_ccr", ccr_o, 0);    chk("rst_sp", sp_o, 8'hFF);
    chk("rst_err", stack_err, 0); chk("rst_req", mem_req, 0);  chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);    chk("rst_addr", address, 0);
    chk("rst_wdata", mem_wdata, 0);

    for (int i = 0; i < NV; i++) begin
      bus1_sel = vecs[i].b1sel; bus2_sel = vecs[i].b2sel; reg_load = vecs[i].rl;
      reg_dst = vecs[i].rdst; pc_load = vecs[i].pcl; pc_inc = vecs[i].pci;
      ir_load = vecs[i].irl; mar_load = vecs[i].marl; ccr_load = vecs[i].ccrl;
      sp_push = vecs[i].push; sp_pop = vecs[i].pop; alu_result = vecs[i].alu;
      nzvc = vecs[i].nz;
      #1;
      chk($sformatf("v%0d_bus1", i), bus1_out, vecs[i].e_bus1);
      step();
      chk($sformatf("v%0d_pc", i), pc_o, vecs[i].e_pc);
      chk($sformatf("v%0d_ir", i), ir_o, vecs[i].e_ir);
      chk($sformatf("v%0d_mar", i), mar_o, vecs[i].e_mar);
      chk($sformatf("v%0d_ccr", i), ccr_o, vecs[i].e_ccr);
      chk($sformatf("v%0d_sp", i), sp_o, vecs[i].e_sp);
      chk($sformatf("v%0d_err", i), stack_err, 0);
    end
    idle_inputs();

    // Memory read: MAR=0x20, ack on third request cycle, MAR reloaded mid-flight.
    bus2_sel = 2'b11; alu_result = 8'h20; mar_load = 1;
    step();
    idle_inputs();
    mem_rd = 1;
    step();
    chk("rd_req1", mem_req, 1); chk("rd_addr1", address, 8'h20); chk("rd_busy1", busy, 1);
    chk("rd_we1", mem_we, 0);   chk("rd_done1", done, 0);
    mem_rd = 0; bus2_sel = 2'b11; alu_result = 8'h30; mar_load = 1;
    step();
    chk("rd_mar30", mar_o, 8'h30); chk("rd_req2", mem_req, 1); chk("rd_addr2", address, 8'h20);
    mar_load = 0; mem_wr = 1;
    step();
    chk("rd_req3", mem_req, 1); chk("rd_addr3", address, 8'h20); chk("rd_we3", mem_we, 0);
    mem_wr = 0; mem_ack = 1; mem_rdata = 8'hA5;
    #1 chk("rd_mdr_pre", mdr_o, 0);
    step();
    chk("rd_mdr", mdr_o, 8'hA5); chk("rd_done", done, 1); chk("rd_req_off", mem_req, 0);
    chk("rd_busy_done", busy, 1); chk("rd_addr4", address, 8'h20);
    mem_rd = 1; mem_rdata = 8'h11;
    step();
    chk("rd_done_off", done, 0); chk("rd_busy_off", busy, 0); chk("rd_ign_req", mem_req, 0);
    chk("rd_mdr_hold", mdr_o, 8'hA5);
    idle_inputs();
    mem_ack = 1;
    step();
    chk("ack_idle_req", mem_req, 0); chk("ack_idle_mdr", mdr_o, 8'hA5);
    idle_inputs();

    // Write aborted by asynchronous reset before ack.
    bus2_sel = 2'b11; alu_result = 8'h5A; reg_load = 1; reg_dst = 2'd1;
    step();
    idle_inputs();
    bus1_sel = 3'b001; mem_wr = 1;
    step();
    mem_wr = 0;
    chk("wr_req", mem_req, 1); chk("wr_we", mem_we, 1); chk("wr_wdata", mem_wdata, 8'h5A);
    #2 reset = 1'b0;
    #1;
    chk("ab_req", mem_req, 0); chk("ab_we", mem_we, 0); chk("ab_busy", busy, 0);
    chk("ab_mdr", mdr_o, 0);   chk("ab_wdata", mem_wdata, 0);
    #2 reset = 1'b1;
    mem_ack = 1; mem_rdata = 8'h3C;
    step();
    chk("ab_idle", busy, 0); chk("ab_mdr2", mdr_o, 0);
    idle_inputs();

    // Stack boundaries.
    sp_pop = 1;
    step();
    chk("pop_ff_sp", sp_o, 8'hFF); chk("pop_ff_err", stack_err, 1);
    sp_pop = 0; sp_push = 1;
    for (int i = 0; i < 255; i++) step();
    chk("push255_sp", sp_o, 8'h00); chk("push255_err", stack_err, 1);
    step();
    chk("push0_sp", sp_o, 8'h00); chk("push0_err", stack_err, 1);
    idle_inputs();

    // Wide instance read after fresh reset.
    #3 reset = 1'b0;
    #4 reset = 1'b1;
    step();
    chk("err_cleared", stack_err, 0); chk("w_rst_sp", w_sp, 16'hFFFF);
    w_bus2_sel = 2'b11; w_alu_result = 16'h1234; w_mar_load = 1;
    step();
    idle_inputs();
    w_mem_rd = 1;
    step();
    w_mem_rd = 0;
    chk("w_req1", w_mem_req, 1); chk("w_addr1", w_address, 16'h1234);
    w_bus2_sel = 2'b11; w_alu_result = 16'h5678; w_mar_load = 1;
    step();
    w_mar_load = 0;
    chk("w_req2", w_mem_req, 1); chk("w_addr2", w_address, 16'h1234);
    step();
    chk("w_req3", w_mem_req, 1);
    w_mem_ack = 1; w_mem_rdata = 16'hBEEF;
    step();
    w_mem_ack = 0;
    chk("w_mdr", w_mdr, 16'hBEEF); chk("w_done", w_done, 1); chk("w_addr3", w_address, 16'h1234);
    step();
    chk("w_done_off", w_done, 0);
    w_bus2_sel = 2'b10; w_reg_load = 1; w_reg_dst = 3'd7;
    step();
    idle_inputs();
    w_bus1_sel = 4'b0111;
    #1 chk("w_r7", w_bus1_out, 16'hBEEF);
    w_bus1_sel = 4'b1010;
    #1 chk("w_b1_mdr", w_bus1_out, 16'hBEEF);
    w_bus1_sel = 4'b1011;
    #1 chk("w_b1_other", w_bus1_out, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/caminho_dados_v2.md
CAMINHO_DADOS_V2 -- requirements
Module: caminho_dados_v2

Interface
REQ-001 Parameter WIDTH, default 8, datapath and address width, legal range 8..32.
REQ-002 Parameter NREGS, default 4, number of general registers, power of two 2..16; RW = log2(NREGS), SW = RW+1.
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; forces reset state immediately on falling edge.
REQ-005 bus1_sel  input  SW  Bus1 source: MSB=0 -> R[low RW bits]; MSB=1 -> low bits 0 PC, 1 SP, 2 MDR, other 0.
REQ-006 bus2_sel  input  2  Bus2 source: 00 Bus1, 01 constant 1, 10 MDR, 11 alu_result.
REQ-007 reg_load  input  1  write Bus2 into R[reg_dst]; reg_dst  input  RW  destination index.
REQ-008 pc_load, pc_inc, ir_load, mar_load, ccr_load  input  1 each  load/increment strobes.
REQ-009 sp_push, sp_pop  input  1 each  stack pointer decrement / increment.
REQ-010 mem_rd, mem_wr  input  1 each  start memory read / write transaction.
REQ-011 mem_ack  input  1  memory completion; mem_rdata  input  WIDTH  read data.
REQ-012 alu_result  input  WIDTH; nzvc  input  4  ALU result and flags.
REQ-013 mem_req, mem_we  output  1  request and write-enable; address, mem_wdata  output  WIDTH.
REQ-014 bus1_out  output  WIDTH  Bus1 value to ALU; IR, PC, SP, MAR, MDR  output  WIDTH; CCR  output  4.
REQ-015 busy, done, stack_err  output  1  transaction active, completion pulse, sticky stack fault.

Function
REQ-016 Bus1, Bus2, bus1_out shall be combinational; bus1_out = Bus1.
REQ-017 R[reg_dst], IR, MAR shall load Bus2 at edge when their strobe is 1, else hold.
REQ-018 PC: pc_load loads Bus2 (priority over pc_inc); pc_inc adds 1 modulo 2^WIDTH (all-ones -> 0).
REQ-019 CCR shall load nzvc when ccr_load=1.
REQ-020 SP: push decrements, pop increments; push and pop together -> no change, no fault.
REQ-021 Push with SP=0 or pop with SP=all-ones shall leave SP unchanged and set stack_err, held until reset.
REQ-022 Memory FSM states IDLE, REQ, DONE; busy=1 in REQ and DONE.
REQ-023 IDLE: mem_rd or mem_wr -> REQ next edge, latching MAR into address reg and Bus1 into mem_wdata reg; mem_rd wins if both.
REQ-024 REQ: mem_req=1, mem_we=1 for write; holds address/wdata stable; stays until mem_ack=1.
REQ-025 REQ with mem_ack=1: read captures mem_rdata into MDR at that edge; -> DONE.
REQ-026 DONE: done=1 for exactly one cycle; -> IDLE; new request accepted the cycle after.
REQ-027 mem_rd/mem_wr asserted while busy shall be ignored (not queued); mem_ack in IDLE/DONE ignored.
REQ-028 MAR changes during REQ shall not alter the address output.
REQ-029 MDR shall load only via REQ-025.

Reset
REQ-030 Reset shall clear R[*], IR, PC, MAR, MDR, CCR, address, mem_wdata, stack_err to 0, set SP to all-ones, FSM to IDLE; mem_req, mem_we, busy, done = 0.
REQ-031 Reset mid-transaction shall abort it: mem_req drops asynchronously, MDR not updated.

Verification
REQ-032 bus2_sel=01, reg_load, reg_dst=2 -> R2=1; bus1_sel=0_10, bus2_sel=00, pc_load -> PC=1.
REQ-033 PC=0xFF, pc_inc -> PC=0x00; pc_load and pc_inc with alu_result=0x40, bus2_sel=11 -> PC=0x40.
REQ-034 MAR=0x20, mem_rd, mem_ack after 3 cycles with rdata=0xA5 -> mem_req high 3 cycles then ack edge, MDR=0xA5, done one cycle, address 0x20 throughout despite MAR reload to 0x30.
REQ-035 After reset pop -> SP=0xFF, stack_err=1; push x255 -> SP=0x00 (fault sticky); one more push -> SP=0x00.
REQ-036 mem_wr with Bus1=0x5A, reset low before ack -> mem_req=0 immediately, MDR=0, FSM IDLE.
REQ-037 Repeat REQ-034 with WIDTH=16, NREGS=8: address 0x1234, rdata 0xBEEF -> MDR=0xBEEF, R7 writable.
